// File: rtl/parallel_lane_packer_if.sv
// Handshake/bus bundle for parallel_lane_packer.
//   master : environment side. Drives in_valid/in_data/in_last/out_stall and
//            observes in_ready and the lane group outputs.
//   slave  : packer side. Mirror of master.
// Signals:
//   in_valid/in_ready/in_data/in_last  serial sample stream with a flush marker
//   out_stall                          downstream back-pressure
//   lanes_out[PAR_FACTOR]              packed group; lane 0 = first beat
//   lanes_en                           one-cycle pulse per delivered group
//   lanes_count                        real (non-pad) lanes in lanes_out
//   lanes_partial                      group was closed early by in_last
interface parallel_lane_packer_if #(
  parameter int PAR_FACTOR = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int CNT_W = $clog2(PAR_FACTOR + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_stall;
  logic [DATA_WIDTH-1:0] lanes_out [PAR_FACTOR];
  logic                  lanes_en;
  logic [CNT_W-1:0]      lanes_count;
  logic                  lanes_partial;

  modport master (
    output in_valid, in_data, in_last, out_stall,
    input  in_ready, lanes_out, lanes_en, lanes_count, lanes_partial
  );

  modport slave (
    input  in_valid, in_data, in_last, out_stall,
    output in_ready, lanes_out, lanes_en, lanes_count, lanes_partial
  );
endinterface

// File: rtl/parallel_lane_packer.sv
// parallel_lane_packer
// Packs a serial stream of DATA_WIDTH samples into PAR_FACTOR-wide lane
// groups for the parallel accumulator. Each group is presented with a
// one-cycle lanes_en pulse. Groups closed early by in_last are zero-padded
// so the padded lanes add nothing to the downstream sum.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  parallel_lane_packer_if.slave (stream input, group output)
// Storage: a fill buffer (fb) collecting the group in progress, and an output
// register (ob) holding the group being presented. Under stall one group
// waits in ob and one complete group may wait in fb; in_ready then drops.
module parallel_lane_packer #(
  parameter int PAR_FACTOR = 4,
  parameter int DATA_WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  parallel_lane_packer_if.slave bus
);

  localparam int CNT_W = $clog2(PAR_FACTOR + 1);
  localparam int IDX_W = $clog2(PAR_FACTOR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_FACTOR - 1);

  typedef logic [DATA_WIDTH-1:0] lane_t;

  // Fill buffer
  lane_t            fb_q [PAR_FACTOR];
  lane_t            fb_d [PAR_FACTOR];
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             fb_full_q, fb_full_d;
  logic [CNT_W-1:0] fb_count_q, fb_count_d;
  logic             fb_partial_q, fb_partial_d;

  // Output register
  lane_t            ob_q [PAR_FACTOR];
  lane_t            ob_d [PAR_FACTOR];
  logic             ob_valid_q, ob_valid_d;
  logic [CNT_W-1:0] ob_count_q, ob_count_d;
  logic             ob_partial_q, ob_partial_d;

  // Combinational helpers
  lane_t            grp [PAR_FACTOR];
  logic [CNT_W-1:0] grp_count;
  logic             grp_partial;
  logic             accept;
  logic             lanes_en;
  logic             ob_free;
  logic             at_end;
  logic             complete;

  always_comb begin
    accept      = bus.in_valid && !fb_full_q;
    lanes_en    = ob_valid_q && !bus.out_stall;
    ob_free     = !ob_valid_q || lanes_en;
    at_end      = (cnt_q == LAST_IDX);
    complete    = accept && (at_end || bus.in_last);
    grp_count   = CNT_W'(cnt_q) + CNT_W'(1);
    grp_partial = !at_end;
    // Completed group: stored lanes below the write index, the current beat
    // at the write index, zero padding above it.
    for (int unsigned i = 0; i < PAR_FACTOR; i++) begin
      if (IDX_W'(i) < cnt_q)
        grp[i] = fb_q[i];
      else if (IDX_W'(i) == cnt_q)
        grp[i] = bus.in_data;
      else
        grp[i] = '0;
    end
  end

  // Output register update. A pending fb group has priority; it cannot
  // coincide with a direct load since no beat is accepted while fb is full.
  always_comb begin
    ob_d         = ob_q;
    ob_valid_d   = ob_valid_q;
    ob_count_d   = ob_count_q;
    ob_partial_d = ob_partial_q;
    if (fb_full_q && ob_free) begin
      ob_d         = fb_q;
      ob_valid_d   = 1'b1;
      ob_count_d   = fb_count_q;
      ob_partial_d = fb_partial_q;
    end else if (complete && ob_free) begin
      ob_d         = grp;
      ob_valid_d   = 1'b1;
      ob_count_d   = grp_count;
      ob_partial_d = grp_partial;
    end else if (lanes_en) begin
      ob_valid_d   = 1'b0;
    end
  end

  // Fill buffer update.
  always_comb begin
    fb_d         = fb_q;
    cnt_d        = cnt_q;
    fb_full_d    = fb_full_q;
    fb_count_d   = fb_count_q;
    fb_partial_d = fb_partial_q;
    if (fb_full_q) begin
      if (ob_free) begin
        fb_d         = '{default: '0};
        fb_full_d    = 1'b0;
        fb_count_d   = '0;
        fb_partial_d = 1'b0;
      end
    end else if (complete) begin
      cnt_d = '0;
      if (ob_free) begin
        fb_d = '{default: '0};
      end else begin
        // Park the finished group until ob drains.
        fb_d         = grp;
        fb_full_d    = 1'b1;
        fb_count_d   = grp_count;
        fb_partial_d = grp_partial;
      end
    end else if (accept) begin
      fb_d[cnt_q] = bus.in_data;
      cnt_d       = cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q         <= '{default: '0};
      cnt_q        <= '0;
      fb_full_q    <= 1'b0;
      fb_count_q   <= '0;
      fb_partial_q <= 1'b0;
      ob_q         <= '{default: '0};
      ob_valid_q   <= 1'b0;
      ob_count_q   <= '0;
      ob_partial_q <= 1'b0;
    end else begin
      fb_q         <= fb_d;
      cnt_q        <= cnt_d;
      fb_full_q    <= fb_full_d;
      fb_count_q   <= fb_count_d;
      fb_partial_q <= fb_partial_d;
      ob_q         <= ob_d;
      ob_valid_q   <= ob_valid_d;
      ob_count_q   <= ob_count_d;
      ob_partial_q <= ob_partial_d;
    end
  end

  assign bus.in_ready      = !fb_full_q;
  assign bus.lanes_en      = lanes_en;
  assign bus.lanes_out     = ob_q;
  assign bus.lanes_count   = ob_count_q;
  assign bus.lanes_partial = ob_partial_q;

endmodule

// File: tb/tb_parallel_lane_packer.sv
module tb_parallel_lane_packer;
  localparam int PF    = 4;
  localparam int DW    = 4;
  localparam int CNT_W = 3;

  typedef struct {
    logic [PF-1:0][DW-1:0] lanes;
    logic [CNT_W-1:0]      cnt;
    logic                  partial;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   n_pulses;
  int   last_pulse_cyc;
  int   prev_pulse_cyc;
  int   acc_cyc;
  exp_t sb[$];

  // Reference packer state
  logic [PF-1:0][DW-1:0] m_lanes;
  int                    m_cnt;

  parallel_lane_packer_if #(.PAR_FACTOR(PF), .DATA_WIDTH(DW)) bus ();

  parallel_lane_packer #(.PAR_FACTOR(PF), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every delivered group is compared with the oldest expected.
  always @(negedge clk) begin
    logic [PF-1:0][DW-1:0] act;
    exp_t e;
    if (!rst && bus.lanes_en === 1'b1) begin
      n_pulses       = n_pulses + 1;
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
      for (int i = 0; i < PF; i++) act[i] = bus.lanes_out[i];
      n_assert = n_assert + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_pulse: got lanes=%h count=%0d partial=%0b, required no pulse",
                 act, bus.lanes_count, bus.lanes_partial);
      end else begin
        e = sb.pop_front();
        if (act !== e.lanes || bus.lanes_count !== e.cnt || bus.lanes_partial !== e.partial) begin
          n_fail = n_fail + 1;
          $display("FAIL group: got lanes=%h count=%0d partial=%0b, required lanes=%h count=%0d partial=%0b",
                   act, bus.lanes_count, bus.lanes_partial, e.lanes, e.cnt, e.partial);
        end
      end
    end
  end

  task automatic model_reset();
    m_lanes = '0;
    m_cnt   = 0;
    sb.delete();
  endtask

  // Present one beat, wait (bounded) for in_ready, update reference model.
  task automatic send(input logic [DW-1:0] d, input logic last, output int waits);
    exp_t e;
    waits        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) begin
      n_assert++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    m_lanes[m_cnt] = d;
    if (last || m_cnt == PF - 1) begin
      e.lanes   = m_lanes;
      e.cnt     = CNT_W'(m_cnt + 1);
      e.partial = (m_cnt + 1 < PF);
      sb.push_back(e);
      m_lanes = '0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [PF-1:0][DW-1:0] act;
    #3;
    for (int i = 0; i < PF; i++) act[i] = bus.lanes_out[i];
    n_assert++;
    if (act !== '0) begin n_fail++; $display("FAIL reset_lanes_out: got %h, required 0", act); end
    n_assert++;
    if (bus.lanes_en !== 1'b0) begin n_fail++; $display("FAIL reset_lanes_en: got %b, required 0", bus.lanes_en); end
    n_assert++;
    if (bus.lanes_count !== '0) begin n_fail++; $display("FAIL reset_lanes_count: got %0d, required 0", bus.lanes_count); end
    n_assert++;
    if (bus.lanes_partial !== 1'b0) begin n_fail++; $display("FAIL reset_lanes_partial: got %b, required 0", bus.lanes_partial); end
    n_assert++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int base, w, acc4;
    base = n_pulses;
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0, w);
    acc4 = acc_cyc;
    idle(3);
    n_assert++;
    if (n_pulses !== base + 1) begin n_fail++; $display("FAIL basic_pulses: got %0d, required %0d", n_pulses - base, 1); end
    n_assert++;
    if (last_pulse_cyc !== acc4) begin n_fail++; $display("FAIL basic_latency: pulse cycle %0d, required %0d", last_pulse_cyc, acc4); end
    n_assert++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int base, w, tw, acc8;
    base = n_pulses;
    tw   = 0;
    for (int i = 1; i <= 8; i++) begin
      send(DW'(i), 1'b0, w);
      tw += w;
    end
    acc8 = acc_cyc;
    idle(3);
    n_assert++;
    if (tw !== 0) begin n_fail++; $display("FAIL b2b_in_ready: got %0d stall cycles, required 0", tw); end
    n_assert++;
    if (n_pulses !== base + 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d, required 2", n_pulses - base); end
    n_assert++;
    if (last_pulse_cyc - prev_pulse_cyc !== 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d, required 4", last_pulse_cyc - prev_pulse_cyc); end
    n_assert++;
    if (last_pulse_cyc !== acc8) begin n_fail++; $display("FAIL b2b_latency: pulse cycle %0d, required %0d", last_pulse_cyc, acc8); end
  endtask

  task automatic test_partial();
    int base, w;
    base = n_pulses;
    send(4'd5, 1'b0, w);
    send(4'd6, 1'b1, w);
    for (int i = 9; i <= 12; i++) send(DW'(i), 1'b0, w);
    idle(3);
    n_assert++;
    if (n_pulses !== base + 2) begin n_fail++; $display("FAIL partial_pulses: got %0d, required 2", n_pulses - base); end
    n_assert++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL partial_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_last_boundary();
    int base, w;
    base = n_pulses;
    send(4'd1, 1'b0, w);
    send(4'd2, 1'b0, w);
    send(4'd3, 1'b0, w);
    send(4'd4, 1'b1, w);
    send(4'hA, 1'b1, w);
    idle(3);
    n_assert++;
    if (n_pulses !== base + 2) begin n_fail++; $display("FAIL last_pulses: got %0d, required 2", n_pulses - base); end
    n_assert++;
    if (bus.lanes_count !== 3'd1 || bus.lanes_partial !== 1'b1) begin
      n_fail++;
      $display("FAIL lone_last_hold: got count=%0d partial=%b, required count=1 partial=1", bus.lanes_count, bus.lanes_partial);
    end
    n_assert++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL last_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_stall();
    int base, w;
    logic [PF-1:0][DW-1:0] act;
    logic [PF-1:0][DW-1:0] req;
    req = {4'd4, 4'd3, 4'd2, 4'd1};
    base = n_pulses;
    bus.out_stall = 1'b1;
    for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", bus.in_ready); end
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < PF; i++) act[i] = bus.lanes_out[i];
      n_assert++;
      if (bus.lanes_en !== 1'b0) begin n_fail++; $display("FAIL stall_lanes_en: got %b, required 0", bus.lanes_en); end
      n_assert++;
      if (act !== req || bus.lanes_count !== 3'd4) begin
        n_fail++;
        $display("FAIL stall_hold: got lanes=%h count=%0d, required lanes=%h count=4", act, bus.lanes_count, req);
      end
    end
    n_assert++;
    if (n_pulses !== base) begin n_fail++; $display("FAIL stall_no_pulse: got %0d, required 0", n_pulses - base); end
    @(posedge clk);
    #1;
    bus.out_stall = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_assert++;
    if (n_pulses !== base + 2) begin n_fail++; $display("FAIL release_pulses: got %0d, required 2", n_pulses - base); end
    n_assert++;
    if (last_pulse_cyc - prev_pulse_cyc !== 1) begin n_fail++; $display("FAIL release_spacing: got %0d, required 1", last_pulse_cyc - prev_pulse_cyc); end
    @(negedge clk);
    n_assert++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b, required 1", bus.in_ready); end
    n_assert++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL release_drain: got %0d pending, required 0", sb.size()); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int base, w;
    logic [PF-1:0][DW-1:0] act;
    bus.out_stall = 1'b1;
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0, w);
    send(4'd3, 1'b0, w);
    send(4'd7, 1'b0, w);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < PF; i++) act[i] = bus.lanes_out[i];
    n_assert++;
    if (act !== '0 || bus.lanes_count !== '0 || bus.lanes_partial !== 1'b0 || bus.lanes_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got lanes=%h count=%0d partial=%b en=%b, required all 0",
               act, bus.lanes_count, bus.lanes_partial, bus.lanes_en);
    end
    n_assert++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b, required 1", bus.in_ready); end
    model_reset();
    bus.out_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = n_pulses;
    for (int i = 1; i <= 4; i++) send(DW'(i), 1'b0, w);
    idle(3);
    n_assert++;
    if (n_pulses !== base + 1) begin n_fail++; $display("FAIL post_reset_pulses: got %0d, required 1", n_pulses - base); end
    n_assert++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL post_reset_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    cyc            = 0;
    n_pulses       = 0;
    last_pulse_cyc = 0;
    prev_pulse_cyc = 0;
    acc_cyc        = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.out_stall  = 1'b0;
    model_reset();

    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_last_boundary();
    test_stall();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
